// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg
//   Shared definitions for the instruction cache: FSM state encoding and
//   the instruction word returned when nothing is fetched (a NOP).
package inst_cache_pkg;

    typedef enum logic [1:0] {
        CACHE_IDLE   = 2'd0,
        CACHE_REFILL = 2'd1,
        CACHE_FILLED = 2'd2
    } cache_state_e;

    localparam logic [31:0] CACHE_NOP = 32'h0000_0000;

endpackage : inst_cache_pkg

// File: rtl/inst_cache_ram.sv
// inst_cache_ram
//   Tag and data storage for the direct-mapped instruction cache.
//   Valid bits are kept in the parent so they can be reset and invalidated.
//
// Ports
//   clk        : clock, writes on posedge
//   rd_index   : line index for the lookup (async read)
//   rd_word    : word within the line for the lookup (async read)
//   rd_tag     : stored tag of line rd_index
//   rd_data    : stored word rd_word of line rd_index
//   wr_en      : write wr_data into line wr_index, word wr_word
//   wr_index   : line being refilled
//   wr_word    : beat number being written
//   wr_data    : beat data
//   tag_wr_en  : write wr_tag into the tag of line wr_index
//   wr_tag     : tag of the line being refilled
module inst_cache_ram #(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16,
    parameter int TAG_W      = 24,
    localparam int WORD_W    = $clog2(LINE_WORDS),
    localparam int INDEX_W   = $clog2(LINES)
) (
    input  logic                clk,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0]   rd_word,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic [31:0]         wr_data,
    input  logic                tag_wr_en,
    input  logic [TAG_W-1:0]    wr_tag
);

    // Data words stored flat, addressed by {index, word}.
    logic [31:0]      data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
        if (tag_wr_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // Asynchronous read so a hit returns the instruction in the same cycle.
    assign rd_data = data_mem[{rd_index, rd_word}];
    assign rd_tag  = tag_mem[rd_index];

endmodule : inst_cache_ram

// File: rtl/inst_cache.sv
// inst_cache
//   Direct-mapped, read-only instruction cache in front of the IF stage.
//   A hit returns the instruction combinationally; a miss stalls the
//   pipeline while one line is refilled beat by beat over a req/ack bus,
//   followed by one bubble cycle before the lookup is retried.
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   inst_ren   : fetch request from IF
//   inst_addr  : fetch byte address (bits [1:0] ignored)
//   inst_data  : fetched instruction, NOP when not hitting
//   inst_stall : pipeline must hold IF/ID
//   invalidate : single-cycle pulse, clears every valid bit
//   mem_req    : backing-memory read request
//   mem_addr   : word-aligned beat address
//   mem_ack    : beat data valid (one pulse per beat)
//   mem_rdata  : beat data
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_ren,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [31:0]           inst_data,
    output logic                  inst_stall,
    input  logic                  invalidate,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - WORD_W - 2;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    // Lookup address fields.
    logic [WORD_W-1:0]  lk_word;
    logic [INDEX_W-1:0] lk_index;
    logic [TAG_W-1:0]   lk_tag;
    logic [1:0]         unused_byte_offset;

    assign lk_word            = inst_addr[WORD_W+1:2];
    assign lk_index           = inst_addr[INDEX_W+WORD_W+1:WORD_W+2];
    assign lk_tag             = inst_addr[ADDR_WIDTH-1:INDEX_W+WORD_W+2];
    assign unused_byte_offset = inst_addr[1:0];

    cache_state_e          state_reg, state_next;
    logic [LINES-1:0]      valid_reg, valid_next;
    logic                  mem_req_reg, mem_req_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [WORD_W-1:0]     beat_reg, beat_next;
    logic [TAG_W-1:0]      fill_tag_reg, fill_tag_next;
    logic [INDEX_W-1:0]    fill_index_reg, fill_index_next;

    logic                  ram_wr_en;
    logic                  tag_wr_en;
    logic [TAG_W-1:0]      rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;

    inst_cache_ram #(
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES),
        .TAG_W      (TAG_W)
    ) u_ram (
        .clk       (clk),
        .rd_index  (lk_index),
        .rd_word   (lk_word),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (ram_wr_en),
        .wr_index  (fill_index_reg),
        .wr_word   (beat_reg),
        .wr_data   (mem_rdata),
        .tag_wr_en (tag_wr_en),
        .wr_tag    (fill_tag_reg)
    );

    // Lookups only resolve in IDLE; during a refill and the bubble cycle
    // the pipeline sees a stall regardless of the address.
    assign hit        = inst_ren && valid_reg[lk_index] && (rd_tag == lk_tag)
                        && (state_reg == CACHE_IDLE);
    assign inst_data  = hit ? rd_data : CACHE_NOP;
    assign inst_stall = inst_ren && !hit;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= CACHE_IDLE;
            valid_reg      <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            beat_reg       <= '0;
            fill_tag_reg   <= '0;
            fill_index_reg <= '0;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            beat_reg       <= beat_next;
            fill_tag_reg   <= fill_tag_next;
            fill_index_reg <= fill_index_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        valid_next      = valid_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        beat_next       = beat_reg;
        fill_tag_next   = fill_tag_reg;
        fill_index_next = fill_index_reg;
        ram_wr_en       = 1'b0;
        tag_wr_en       = 1'b0;

        case (state_reg)
            CACHE_IDLE: begin
                if (inst_ren && !hit) begin
                    fill_tag_next   = lk_tag;
                    fill_index_next = lk_index;
                    beat_next       = '0;
                    mem_req_next    = 1'b1;
                    mem_addr_next   = {lk_tag, lk_index, {WORD_W{1'b0}}, 2'b00};
                    state_next      = CACHE_REFILL;
                end
            end
            CACHE_REFILL: begin
                // Refill always completes for the latched line, even if the
                // fetch address changes or inst_ren drops meanwhile.
                if (mem_ack) begin
                    ram_wr_en = 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        tag_wr_en                   = 1'b1;
                        valid_next[fill_index_reg]  = 1'b1;
                        mem_req_next                = 1'b0;
                        state_next                  = CACHE_FILLED;
                    end else begin
                        beat_next     = beat_reg + WORD_W'(1);
                        mem_addr_next = mem_addr_reg + ADDR_WIDTH'(4);
                    end
                end
            end
            CACHE_FILLED: begin
                state_next = CACHE_IDLE;
            end
            default: begin
                state_next = CACHE_IDLE;
            end
        endcase

        // Applied last so it overrides a line becoming valid this cycle.
        if (invalidate) begin
            valid_next = '0;
        end
    end

endmodule : inst_cache

// File: tb/tb_inst_cache.sv
// tb_inst_cache
//   Directed bench for inst_cache with a behavioural instruction memory
//   whose word at byte address A is 0x2000_0000 + A/4, and a configurable
//   number of wait cycles before each beat is acknowledged.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_ren = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        invalidate = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    int          mem_delay = 0;
    int          wait_cnt = 0;
    int          stable_errs = 0;
    logic [31:0] wait_addr = 32'h0;
    logic [31:0] ack_log [$];

    inst_cache #(
        .LINE_WORDS (4),
        .LINES      (16),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_ren   (inst_ren),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .inst_stall (inst_stall),
        .invalidate (invalidate),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: acknowledges a request after mem_delay wait cycles,
    // and flags any change of request/address while a beat is pending.
    always @(negedge clk) begin
        if (!mem_req) begin
            if (wait_cnt != 0) stable_errs++;
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) wait_addr = mem_addr;
            else if (mem_addr != wait_addr) stable_errs++;
            if (wait_cnt == mem_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h2000_0000 + (mem_addr >> 2);
                ack_log.push_back(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Presents addr until the stall clears; checks cycles-to-hit, data and,
    // for a miss, the beat addresses seen on the memory bus.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input int exp_lat, input logic [31:0] exp_data);
        int          cyc;
        bit          done;
        logic [31:0] line_addr;
        cyc = 0;
        done = 0;
        line_addr = addr & 32'hFFFF_FFF0;
        ack_log.delete();
        while (!done && cyc < 200) begin
            @(negedge clk);
            inst_ren  = 1'b1;
            inst_addr = addr;
            #1;
            if (!inst_stall) done = 1;
            else cyc++;
        end
        check_value({tag, "_latency"}, cyc, exp_lat);
        check_value({tag, "_data"}, inst_data, exp_data);
        if (exp_lat > 0) begin
            check_value({tag, "_beats"}, ack_log.size(), 4);
            for (int i = 0; i < 4; i++) begin
                if (i < ack_log.size())
                    check_value($sformatf("%s_addr%0d", tag, i), ack_log[i],
                                line_addr + 32'(4 * i));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_mem_req", mem_req, 0);
        check_value("rst_mem_addr", mem_addr, 0);
        check_value("rst_stall_noren", inst_stall, 0);
        check_value("rst_data_noren", inst_data, 0);
        @(negedge clk);
        inst_ren = 1'b1;
        #1;
        check_value("rst_stall_ren", inst_stall, 1);
        @(negedge clk);
        rst_n = 1'b1;
        inst_ren = 1'b0;

        // 1: cold miss, then hit on another word of the same line
        fetch("cold", 32'h0, 6, 32'h2000_0000);
        fetch("hit8", 32'h8, 0, 32'h2000_0002);
        @(negedge clk);
        inst_ren = 1'b0;
        #1;
        check_value("noren_stall", inst_stall, 0);
        check_value("noren_data", inst_data, 0);

        // 2: conflict on index 0
        fetch("conflict", 32'h100, 6, 32'h2000_0040);
        fetch("refetch0", 32'h0, 6, 32'h2000_0000);

        // 3: slow memory, 3 wait cycles per beat
        mem_delay = 3;
        stable_errs = 0;
        fetch("slow", 32'h200, 18, 32'h2000_0080);
        check_value("slow_stable", stable_errs, 0);
        mem_delay = 0;

        // 4: redirect from 0x40 to 0x80 while beat 2 is being acked
        begin
            int  cyc;
            bit  done;
            cyc = 0;
            done = 0;
            ack_log.delete();
            while (!done && cyc < 200) begin
                @(negedge clk);
                inst_ren  = 1'b1;
                inst_addr = (cyc >= 3) ? 32'h80 : 32'h40;
                #1;
                if (!inst_stall) done = 1;
                else cyc++;
            end
            check_value("redir_latency", cyc, 12);
            check_value("redir_data", inst_data, 32'h2000_0020);
            check_value("redir_beats", ack_log.size(), 8);
            if (ack_log.size() == 8) begin
                check_value("redir_first", ack_log[0], 32'h40);
                check_value("redir_second", ack_log[4], 32'h80);
            end
        end
        fetch("redir_40", 32'h40, 0, 32'h2000_0010);

        // 5: invalidate coinciding with the last beat of a refill of 0x0
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            inst_ren   = 1'b1;
            inst_addr  = 32'h0;
            invalidate = (cyc == 4);
            #1;
        end
        invalidate = 1'b0;
        check_value("inv_req_done", mem_req, 0);
        fetch("inv_0", 32'h0, 6, 32'h2000_0000);
        fetch("inv_40", 32'h40, 6, 32'h2000_0010);
        fetch("inv_80", 32'h80, 6, 32'h2000_0020);

        // 6: reset asserted in the middle of a refill
        @(negedge clk);
        inst_ren  = 1'b1;
        inst_addr = 32'h300;
        @(negedge clk);
        #1;
        check_value("mid_req", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("arst_req", mem_req, 0);
        check_value("arst_addr", mem_addr, 0);
        check_value("arst_stall", inst_stall, 1);
        @(negedge clk);
        rst_n = 1'b1;
        inst_ren = 1'b0;
        #1;
        check_value("post_rst_stall", inst_stall, 0);
        fetch("post_rst", 32'h300, 6, 32'h2000_00C0);
        fetch("post_rst_40", 32'h40, 6, 32'h2000_0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_cache
